fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter FETCH_WIDTH, default 2: instruction slots per ibus response, power of two, 1..8.
REQ-002 Parameter DEPTH, default 8: queue entries, power of two, >= 2*FETCH_WIDTH.
REQ-003 Parameter DECODE_WIDTH, default 2: slots presented to decode per cycle, <= FETCH_WIDTH.
REQ-004 Parameter RESET_PC, default 64'h8000_0000: first fetch address.
REQ-005 clk  input  1  sole clock; all state on its rising edge.
REQ-006 resetn  input  1  synchronous, active-low reset.
REQ-007 redirect_valid  input  1  flush and restart fetch at redirect_pc.
REQ-008 redirect_pc  input  64  restart address, 4-byte aligned.
REQ-009 ireq_valid  output  1  fetch request valid.
REQ-010 ireq_addr  output  64  request address, aligned to FETCH_WIDTH*4 bytes.
REQ-011 ireq_ready  input  1  ibus accepts request when ireq_valid && ireq_ready.
REQ-012 iresp_valid  input  1  response for the single outstanding request.
REQ-013 iresp_data  input  FETCH_WIDTH x 32  raw instructions, slot i at ireq_addr + 4*i.
REQ-014 deq_valid  output  DECODE_WIDTH  per-slot valid, contiguous from slot 0.
REQ-015 deq_instr / deq_pc  output  DECODE_WIDTH x 32 / x 64  instruction and its pc.
REQ-016 deq_ready  input  1  decode consumes every slot with deq_valid high this cycle.

Function
REQ-017 FSM states: RUN (no request outstanding), WAIT (request accepted, response pending), DROP (outstanding response must be discarded).
REQ-018 RUN: ireq_valid = 1 iff free entries >= FETCH_WIDTH and no redirect this cycle; handshake moves to WAIT.
REQ-019 WAIT: on iresp_valid, write valid slots to queue tail in pc order, fetch_pc += FETCH_WIDTH*4 (aligned), return to RUN; earliest next request is the following cycle.
REQ-020 ireq_addr = fetch_pc with low log2(FETCH_WIDTH*4) bits cleared; ireq_addr and ireq_valid held stable while ireq_valid && !ireq_ready.
REQ-021 Misaligned start: on the first response after reset or redirect, slots below fetch_pc[log2(FETCH_WIDTH*4)-1:2] are dropped and not enqueued.
REQ-022 Dequeue: up to DECODE_WIDTH oldest entries shown; deq_valid[i] = 1 iff occupancy > i; deq_ready pops popcount(deq_valid).
REQ-023 Enqueue and dequeue in the same cycle are both honoured; occupancy = old + enq - deq, never exceeds DEPTH.
REQ-024 Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty decided from the extra bit.
REQ-025 Redirect, any state: queue emptied the next cycle, fetch_pc <= redirect_pc, deq_valid all 0 that cycle's next edge; same-cycle iresp_valid and deq_ready ignored.
REQ-026 Redirect in WAIT without same-cycle iresp_valid -> DROP; DROP discards the next iresp_valid then -> RUN; redirect in DROP only updates fetch_pc.
REQ-027 Redirect has priority over every other event; a pending unaccepted request is withdrawn (ireq_valid low) in the redirect cycle.

Reset
REQ-028 While resetn = 0 at a clock edge: state RUN, fetch_pc = RESET_PC, queue empty, misaligned-start flag set.
REQ-029 Outputs under reset: ireq_valid = 0, deq_valid = 0; ireq_addr, deq_instr, deq_pc = 0.
REQ-030 Reset mid-WAIT abandons the request; the ibus is reset with the same resetn, so no response is dropped explicitly.

Structure
REQ-031 FETCH_WIDTH default, fetch_state_t enum and the instruction entry struct (raw_instr, pc) belong in fetch_pkg.
REQ-032 Storage is one sub-module, fetch_queue_ram: DEPTH entries, FETCH_WIDTH write ports, DECODE_WIDTH read ports, no reset on data.

Verification
REQ-033 Reset release, ireq_ready = 1, response one cycle later -> first ireq_addr 0x8000_0000, next 0x8000_0008 (defaults).
REQ-034 Redirect to 0x8000_0104 (FETCH_WIDTH = 2) -> ireq_addr 0x8000_0100, only instruction at 0x...104 enqueued.
REQ-035 deq_ready = 0 for 10 cycles with continuous responses -> occupancy stops at 8, ireq_valid low, no entry lost or reordered.
REQ-036 Redirect in WAIT, response 3 cycles later -> response discarded, next ireq_addr = redirect target.
REQ-037 Redirect coinciding with iresp_valid and deq_ready -> nothing enqueued, nothing dequeued, queue empty next cycle.
REQ-038 Random stall/redirect run, 10k cycles, against a reference pc model -> deq_pc stream matches the sequential pc sequence between redirects.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and defaults for the instruction fetch queue.
//   - *_DEFAULT localparams : default parameter values for fetch_queue
//   - fetch_state_t         : request tracking state (RUN / WAIT / DROP)
//   - fetch_entry_t         : one queued instruction (raw encoding + its pc)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH_DEFAULT  = 2;
  localparam int unsigned DEPTH_DEFAULT        = 8;
  localparam int unsigned DECODE_WIDTH_DEFAULT = 2;
  localparam logic [63:0] RESET_PC_DEFAULT     = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // request accepted, response pending
    ST_DROP = 2'd2   // outstanding response is stale and must be discarded
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the redirect, instruction-bus and decode handshakes of fetch_queue.
//   redirect_valid/redirect_pc : flush and restart fetch
//   ireq_valid/ireq_addr/ireq_ready : fetch request to the ibus
//   iresp_valid/iresp_data     : response, FETCH_WIDTH x 32-bit slots
//   deq_valid/deq_instr/deq_pc/deq_ready : DECODE_WIDTH slots to decode
// Modports: master = fetch_queue side, slave = ibus/decode/redirect side.
// -----------------------------------------------------------------------------
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = FETCH_WIDTH_DEFAULT,
  parameter int unsigned DECODE_WIDTH = DECODE_WIDTH_DEFAULT
);

  logic                               redirect_valid;
  logic [63:0]                        redirect_pc;

  logic                               ireq_valid;
  logic [63:0]                        ireq_addr;
  logic                               ireq_ready;

  logic                               iresp_valid;
  logic [FETCH_WIDTH-1:0][31:0]       iresp_data;

  logic [DECODE_WIDTH-1:0]            deq_valid;
  logic [DECODE_WIDTH-1:0][31:0]      deq_instr;
  logic [DECODE_WIDTH-1:0][63:0]      deq_pc;
  logic                               deq_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    input  ireq_ready, iresp_valid, iresp_data, deq_ready,
    output ireq_valid, ireq_addr, deq_valid, deq_instr, deq_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output ireq_ready, iresp_valid, iresp_data, deq_ready,
    input  ireq_valid, ireq_addr, deq_valid, deq_instr, deq_pc
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// -----------------------------------------------------------------------------
// fetch_queue_ram
// Entry storage for fetch_queue: DEPTH entries, WR_PORTS synchronous write
// ports and RD_PORTS asynchronous read ports. Data is never reset; validity
// is tracked by the owner's pointers.
//   clk             : clock
//   wr_en/addr/data : per-port write (ports never target the same address)
//   rd_addr/rd_data : per-port combinational read
// -----------------------------------------------------------------------------
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned WR_PORTS = FETCH_WIDTH_DEFAULT,
  parameter int unsigned RD_PORTS = DECODE_WIDTH_DEFAULT,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [WR_PORTS-1:0] wr_en,
  input  logic [AW-1:0]       wr_addr [WR_PORTS],
  input  fetch_entry_t        wr_data [WR_PORTS],
  input  logic [AW-1:0]       rd_addr [RD_PORTS],
  output fetch_entry_t        rd_data [RD_PORTS]
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p]) begin
        mem[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_data[r] = mem[rd_addr[r]];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front end: issues aligned block requests to the ibus,
// queues the returned instructions with their pcs, and presents up to
// DECODE_WIDTH oldest entries to decode per cycle. A redirect flushes the
// queue and restarts fetch; a response still in flight is discarded.
//   clk    : clock, all state on the rising edge
//   resetn : synchronous active-low reset
//   bus    : fetch_queue_if.master (redirect, ibus request/response, decode)
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = FETCH_WIDTH_DEFAULT,
  parameter int unsigned DEPTH        = DEPTH_DEFAULT,
  parameter int unsigned DECODE_WIDTH = DECODE_WIDTH_DEFAULT,
  parameter logic [63:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_queue_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LB = $clog2(FETCH_WIDTH * 4);   // byte-offset bits of a fetch block
  localparam int unsigned SW = (LB > 2) ? (LB - 2) : 1;   // slot-index width
  localparam logic [63:0] BLOCK_BYTES = 64'(FETCH_WIDTH * 4);

  // One extra pointer bit lets wr - rd span 0..DEPTH, so full and empty
  // are distinguishable without a separate counter.
  typedef logic [AW:0] ptr_t;

  fetch_state_t  state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic          misalign_q, misalign_d;
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;

  ptr_t          occ, deq_cnt, n_deq, n_enq;
  logic [63:0]   block_pc;
  logic [SW-1:0] start_slot;
  logic          free_ok, req_valid, enq_en;

  logic [FETCH_WIDTH-1:0] wr_en;
  logic [AW-1:0]          wr_addr  [FETCH_WIDTH];
  fetch_entry_t           wr_data  [FETCH_WIDTH];
  logic [SW-1:0]          src_slot [FETCH_WIDTH];
  logic [AW-1:0]          rd_addr  [DECODE_WIDTH];
  fetch_entry_t           rd_data  [DECODE_WIDTH];
  logic [DECODE_WIDTH-1:0] deq_vld;

  assign block_pc = {fetch_pc_q[63:LB], {LB{1'b0}}};
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign deq_cnt  = (occ > ptr_t'(DECODE_WIDTH)) ? ptr_t'(DECODE_WIDTH) : occ;
  // A request is only issued when a whole block is guaranteed to fit, so the
  // response can always be written without back-pressure.
  assign free_ok  = (ptr_t'(DEPTH) - occ) >= ptr_t'(FETCH_WIDTH);
  // After reset/redirect the target may sit mid-block; leading slots are skipped.
  assign start_slot = misalign_q ? SW'(fetch_pc_q[LB-1:0] >> 2) : '0;
  assign n_enq      = ptr_t'(FETCH_WIDTH) - ptr_t'(start_slot);

  // Next-state / control. Redirect overrides every other event.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    misalign_d = misalign_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    req_valid  = 1'b0;
    enq_en     = 1'b0;
    n_deq      = '0;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      misalign_d = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      case (state_q)
        ST_RUN:  state_d = ST_RUN;
        // A response arriving with the redirect closes the transaction;
        // otherwise the one still in flight must be thrown away later.
        ST_WAIT,
        ST_DROP: state_d = bus.iresp_valid ? ST_RUN : ST_DROP;
        default: state_d = ST_RUN;
      endcase
    end else begin
      if (bus.deq_ready) begin
        n_deq = deq_cnt;
      end
      rd_ptr_d = rd_ptr_q + n_deq;

      case (state_q)
        ST_RUN: begin
          req_valid = free_ok;
          if (free_ok && bus.ireq_ready) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.iresp_valid) begin
            enq_en     = 1'b1;
            wr_ptr_d   = wr_ptr_q + n_enq;
            fetch_pc_d = block_pc + BLOCK_BYTES;
            misalign_d = 1'b0;
            state_d    = ST_RUN;
          end
        end
        ST_DROP: begin
          if (bus.iresp_valid) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Write port j carries response slot start_slot + j, packed at the tail.
  always_comb begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      src_slot[j]          = start_slot + SW'(j);
      wr_en[j]             = enq_en && (ptr_t'(j) < n_enq);
      wr_addr[j]           = wr_ptr_q[AW-1:0] + AW'(j);
      wr_data[j].raw_instr = bus.iresp_data[src_slot[j]];
      wr_data[j].pc        = block_pc + (64'(src_slot[j]) << 2);
    end
  end

  fetch_queue_ram #(
    .DEPTH    (DEPTH),
    .WR_PORTS (FETCH_WIDTH),
    .RD_PORTS (DECODE_WIDTH),
    .AW       (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Outputs are forced to zero while reset is asserted.
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rd_addr[i]       = rd_ptr_q[AW-1:0] + AW'(i);
      deq_vld[i]       = resetn && (occ > ptr_t'(i));
      bus.deq_instr[i] = deq_vld[i] ? rd_data[i].raw_instr : '0;
      bus.deq_pc[i]    = deq_vld[i] ? rd_data[i].pc : '0;
    end
  end

  assign bus.deq_valid  = deq_vld;
  assign bus.ireq_valid = resetn && req_valid;
  assign bus.ireq_addr  = resetn ? block_pc : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench: a transaction-level model (queue of {pc, instr},
// fetch pc, outstanding/discard flags) predicts every output each cycle,
// a second check follows the dequeued pc stream, and directed scenarios pin
// literal values before a long randomized stall/redirect run.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 8;
  localparam logic [63:0] RPC = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW)) fq_if ();

  fetch_queue #(
    .FETCH_WIDTH  (FW),
    .DEPTH        (DEPTH),
    .DECODE_WIDTH (DW),
    .RESET_PC     (RPC)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (fq_if)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  ent_t        mq[$];
  logic [63:0] m_pc = RPC;
  bit          m_first = 1'b1;
  bit          m_out = 1'b0;
  bit          m_discard = 1'b0;
  logic [63:0] seq_pc = RPC;

  // ibus responder
  bit          bus_pend = 1'b0;
  logic [63:0] bus_addr = '0;
  int          bus_delay = 0;
  bit          auto_rv = 1'b0;

  // outputs sampled in the last step
  logic          s_ivalid;
  logic [63:0]   s_iaddr;
  logic [DW-1:0] s_dvalid;
  logic [63:0]   s_dpc0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input bit rd, input logic [63:0] rpc, input bit rr,
                      input bit rv_req, input bit dr);
    bit          rv;
    bit          exp_iv;
    logic [63:0] blk;
    int          start;
    int          n;
    ent_t        e;
    exp_iv = 1'b0;
    @(negedge clk);
    rv = bus_pend && (auto_rv ? (bus_delay == 0) : rv_req);
    fq_if.redirect_valid = rd;
    fq_if.redirect_pc    = rpc;
    fq_if.ireq_ready     = rr;
    fq_if.iresp_valid    = rv;
    fq_if.deq_ready      = dr;
    for (int i = 0; i < FW; i++)
      fq_if.iresp_data[i] = rv ? instr_of(bus_addr + 64'(4 * i)) : 32'hDEAD_BEEF;
    #1;
    blk = m_pc & ~64'(FW * 4 - 1);
    if (!resetn) begin
      chk("rst_ireq_valid", 64'(fq_if.ireq_valid), 64'd0);
      chk("rst_ireq_addr", fq_if.ireq_addr, 64'd0);
      chk("rst_deq_valid", 64'(fq_if.deq_valid), 64'd0);
      chk("rst_deq_instr", 64'(fq_if.deq_instr), 64'd0);
      for (int i = 0; i < DW; i++) chk("rst_deq_pc", fq_if.deq_pc[i], 64'd0);
    end else begin
      exp_iv = !m_out && ((DEPTH - mq.size()) >= FW) && !rd;
      chk("ireq_valid", 64'(fq_if.ireq_valid), 64'(exp_iv));
      chk("ireq_addr", fq_if.ireq_addr, blk);
      for (int i = 0; i < DW; i++) begin
        chk("deq_valid", 64'(fq_if.deq_valid[i]), 64'(mq.size() > i));
        if (mq.size() > i) begin
          chk("deq_pc", fq_if.deq_pc[i], mq[i].pc);
          chk("deq_instr", 64'(fq_if.deq_instr[i]), 64'(mq[i].instr));
        end
      end
      if (!rd && dr) begin
        for (int i = 0; i < DW; i++) begin
          if (fq_if.deq_valid[i]) begin
            chk("deq_pc_stream", fq_if.deq_pc[i], seq_pc);
            seq_pc = seq_pc + 64'd4;
          end
        end
      end
    end
    s_ivalid = fq_if.ireq_valid;
    s_iaddr  = fq_if.ireq_addr;
    s_dvalid = fq_if.deq_valid;
    s_dpc0   = fq_if.deq_pc[0];

    @(posedge clk);
    if (!resetn) begin
      mq.delete();
      m_pc = RPC; m_first = 1'b1; m_out = 1'b0; m_discard = 1'b0;
      bus_pend = 1'b0; seq_pc = RPC;
    end else begin
      if (bus_pend && !rv && bus_delay > 0) bus_delay--;
      if (rv) bus_pend = 1'b0;
      if (rd) begin
        mq.delete();
        m_pc = rpc; m_first = 1'b1; seq_pc = rpc;
        if (rv) begin
          m_out = 1'b0; m_discard = 1'b0;
        end else if (m_out) begin
          m_discard = 1'b1;
        end
      end else begin
        if (dr) begin
          n = (mq.size() < DW) ? mq.size() : DW;
          repeat (n) void'(mq.pop_front());
        end
        if (rv && m_out) begin
          if (!m_discard) begin
            start = m_first ? int'((m_pc - blk) >> 2) : 0;
            for (int i = start; i < FW; i++) begin
              e.pc    = blk + 64'(4 * i);
              e.instr = instr_of(e.pc);
              mq.push_back(e);
            end
            m_pc = blk + 64'(FW * 4);
            m_first = 1'b0;
          end
          m_out = 1'b0; m_discard = 1'b0;
        end
        if (exp_iv && rr) m_out = 1'b1;
      end
      if (s_ivalid && rr) begin
        bus_pend  = 1'b1;
        bus_addr  = s_iaddr;
        bus_delay = $urandom_range(0, 3);
      end
    end
  endtask

  initial begin
    fq_if.redirect_valid = 1'b0;
    fq_if.redirect_pc    = '0;
    fq_if.ireq_ready     = 1'b0;
    fq_if.iresp_valid    = 1'b0;
    fq_if.iresp_data     = '0;
    fq_if.deq_ready      = 1'b0;

    resetn = 1'b0;
    repeat (3) step(0, 64'd0, 0, 0, 0);
    resetn = 1'b1;

    // first fetch after reset, response one cycle later
    step(0, 64'd0, 1, 0, 0);
    chk("first_addr", s_iaddr, 64'h8000_0000);
    chk("first_valid", 64'(s_ivalid), 64'd1);
    step(0, 64'd0, 1, 1, 0);
    step(0, 64'd0, 0, 0, 0);
    chk("second_addr", s_iaddr, 64'h8000_0008);
    chk("after_first_deq_valid", 64'(s_dvalid), 64'b11);

    // misaligned redirect: only the upper slot is enqueued
    step(1, 64'h8000_0104, 1, 0, 0);
    chk("redirect_withdraw", 64'(s_ivalid), 64'd0);
    step(0, 64'd0, 1, 0, 0);
    chk("misalign_addr", s_iaddr, 64'h8000_0100);
    chk("misalign_flushed", 64'(s_dvalid), 64'd0);
    step(0, 64'd0, 0, 1, 0);
    step(0, 64'd0, 0, 0, 0);
    chk("misalign_deq_valid", 64'(s_dvalid), 64'b01);
    chk("misalign_deq_pc", s_dpc0, 64'h8000_0104);

    // decode stalled with continuous responses: queue fills to DEPTH
    step(1, 64'h8000_0200, 0, 0, 0);
    repeat (10) step(0, 64'd0, 1, 1, 0);
    step(0, 64'd0, 1, 1, 0);
    chk("full_ireq_valid", 64'(s_ivalid), 64'd0);
    chk("full_deq_valid", 64'(s_dvalid), 64'b11);
    chk("full_model_occ", 64'(mq.size()), 64'd8);
    chk("full_head_pc", s_dpc0, 64'h8000_0200);
    repeat (5) step(0, 64'd0, 0, 0, 1);

    // redirect while waiting; stale response 3 cycles later is dropped
    step(0, 64'd0, 1, 0, 0);
    step(1, 64'h8000_1000, 0, 0, 0);
    step(0, 64'd0, 1, 0, 0);
    chk("drop_no_req", 64'(s_ivalid), 64'd0);
    step(0, 64'd0, 1, 0, 0);
    step(0, 64'd0, 0, 1, 0);
    step(0, 64'd0, 1, 0, 0);
    chk("drop_next_addr", s_iaddr, 64'h8000_1000);
    chk("drop_next_valid", 64'(s_ivalid), 64'd1);
    chk("drop_nothing_queued", 64'(s_dvalid), 64'd0);

    // redirect together with response and dequeue
    step(0, 64'd0, 0, 1, 0);
    step(0, 64'd0, 1, 0, 0);
    chk("pre_collide_deq_valid", 64'(s_dvalid), 64'b11);
    step(1, 64'h8000_2000, 0, 1, 1);
    step(0, 64'd0, 0, 0, 0);
    chk("collide_empty", 64'(s_dvalid), 64'd0);
    chk("collide_addr", s_iaddr, 64'h8000_2000);
    chk("collide_model_empty", 64'(mq.size()), 64'd0);

    // randomized stalls, latencies and redirects, with one mid-run reset
    auto_rv = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      resetn = !(c == 5000 || c == 5001);
      step(($urandom_range(0, 49) == 0), {$urandom, $urandom} & ~64'h3,
           ($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
